esn_sample_framer: RTL
======================

Name: esn_sample_framer

Overview:
- Downstream stage of the input-sample ROM reader.
- Consumes the 16-bit sample stream, which the ROM produces one read-latency after each clock-enable.
- Buffers samples in a small show-ahead FIFO and presents them to the reservoir datapath on a valid/ready interface.
- Tags the last sample of every fixed-length frame and counts completed frames.
- Drives a stall signal back to the upstream counter so it can throttle reads.

Parameters:
- WIDTH, 16: sample width in bits.
- DEPTH, 8: FIFO entries; must be a power of two and at least 2.
- RD_LAT, 1: cycles from upstream ce to valid din; range 1..4.
- FRAME_LEN, 64: samples per frame; range 2..65536.

Ports:
- clk  in  1  system clock, rising edge.
- sclr  in  1  reset, asynchronous, active-low.
- ce  in  1  upstream read enable, same signal that drives the ROM rden.
- din  in  WIDTH  ROM output data; valid RD_LAT cycles after ce.
- flush  in  1  synchronous clear of buffered and in-flight data.
- stall  out  1  high means upstream must not assert ce this cycle.
- out_valid  out  1  out_data holds a valid sample.
- out_ready  in  1  consumer accepts the sample.
- out_data  out  WIDTH  FIFO head sample.
- out_last  out  1  out_data is the final sample of a frame.
- overflow  out  1  sticky flag: a sample was dropped.
- frame_cnt  out  16  completed frames; wraps at 2^16.

Behaviour:
- Reset (sclr=0, asynchronous):
  - FIFO empty; delay line cleared; sample index cleared.
  - out_valid=0, out_data=0, out_last=0, overflow=0, frame_cnt=0, stall=0.
- Delay line:
  - RD_LAT-deep shift register of ce bits.
  - in_valid is the tail bit; din is sampled on the edge where in_valid=1.
- Push = in_valid.
  - Accepted if FIFO is not full, or if a pop happens in the same cycle.
  - Push to a full FIFO with no pop: sample dropped, overflow set to 1; it stays 1 until reset.
- Pop = out_valid and out_ready. FIFO is show-ahead: out_data is the head entry, combinational from storage.
- Occupancy count, width log2(DEPTH)+1:
  - +1 on an accepted push only.
  - -1 on a pop only.
  - Unchanged when both occur.
- out_valid = (count != 0). out_data is don't-care when out_valid=0; the bench only checks it while out_valid=1.
- Latency with the FIFO empty and out_ready=1:
  - ce high at cycle t; din valid at t+RD_LAT; out_valid=1 at t+RD_LAT+1.
- Sample index (0..FRAME_LEN-1):
  - Increments on every pop; wraps to 0 after FRAME_LEN-1.
  - out_last = out_valid and (index == FRAME_LEN-1).
  - A pop with out_last=1 increments frame_cnt.
- stall (combinational) = (count + number of 1s in delay line) >= DEPTH.
  - Guarantees no overflow when upstream honours it.
  - Does not account for a pop in the current cycle; this is conservative by design.
- flush=1 on a clock edge:
  - Empties the FIFO; clears the delay line and sample index.
  - Keeps overflow and frame_cnt.
  - Pushes and pops in that cycle are discarded.
  - out_valid=0 on the next cycle.
- ce during flush: the ce bit is discarded (delay line cleared).
- Pointers are log2(DEPTH) bits and wrap naturally. A 2-cycle mid-stream reset pulse returns every output to its reset value immediately, without waiting for a clock edge.

Test Plan:
1. Reset values: hold sclr=0 with ce toggling -> all outputs 0; release, no ce -> out_valid stays 0 for 10 cycles.
2. Single-sample latency: ce=1 at cycle 5, din=0x1234 at cycle 6, out_ready=1 -> out_valid=1 and out_data=0x1234 at cycle 7 only; out_last=0.
3. Frame boundary: 64 consecutive ce, din=index 0..63, out_ready=1 -> out_last=1 exactly when out_data=63; frame_cnt goes 0->1. Run 2 more frames -> frame_cnt=3.
4. Backpressure and overflow: out_ready=0, ce held 10 cycles ignoring stall, din=0xA000+i.
   - stall rises once count plus in-flight reaches 8.
   - overflow=1.
   - Drain yields exactly 0xA000..0xA007 in order.
5. Stall honoured, random out_ready (50%), 200 samples, upstream gates ce with ~stall -> overflow stays 0; output order matches input; out_last every 64th pop.
6. Full with simultaneous push/pop: fill to 8, then out_ready=1 and in_valid=1 on the same cycle -> count stays 8, no overflow, new sample appears after the 7 older ones. Then flush -> out_valid=0 next cycle; overflow and frame_cnt unchanged.

Source files
------------

// File: rtl/esn_sample_framer.sv
// Sample framer: buffers ROM read data in a show-ahead FIFO, presents it on a
// valid/ready interface, tags the last sample of each frame and throttles the
// upstream read counter through a conservative stall.
module esn_sample_framer #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned FRAME_LEN = 64
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  input  logic             flush,
  output logic             stall,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             overflow,
  output logic [15:0]      frame_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned IdxW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  // Wide enough for DEPTH plus up to four in-flight reads.
  localparam int unsigned SumW = CntW + 3;

  localparam logic [IdxW-1:0] LastIdx  = IdxW'(FRAME_LEN - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic [RD_LAT-1:0] ce_pipe_q, ce_pipe_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              overflow_q, overflow_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic              in_valid;
  logic              full;
  logic              pop;
  logic              push_ok;
  logic              mem_we;
  logic [SumW-1:0]   inflight_cnt;

  assign in_valid = ce_pipe_q[RD_LAT-1];
  assign full     = (count_q == DepthCnt);
  assign pop      = out_valid && out_ready;
  // A pop frees the head slot on the same edge, so a full FIFO can still accept.
  assign push_ok  = in_valid && (!full || pop);
  assign mem_we   = push_ok && !flush;

  // Output view of the FIFO head and frame position.
  always_comb begin
    out_valid = (count_q != '0);
    out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    out_last  = out_valid && (idx_q == LastIdx);
    overflow  = overflow_q;
    frame_cnt = frame_cnt_q;
  end

  // Stall ignores a pop in the current cycle; reads already issued must still fit.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_cnt = inflight_cnt + SumW'(ce_pipe_q[i]);
    end
    stall = (SumW'(count_q) + inflight_cnt) >= SumW'(DEPTH);
  end

  // Read-latency delay line of ce; flush drops every pending read including this one.
  always_comb begin
    ce_pipe_d = '0;
    if (!flush) begin
      ce_pipe_d[0] = ce;
      for (int i = 1; i < RD_LAT; i++) begin
        ce_pipe_d[i] = ce_pipe_q[i-1];
      end
    end
  end

  // FIFO pointers, occupancy, frame index and sticky status next state.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    overflow_d  = overflow_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      idx_d    = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (in_valid && full && !pop) begin
        overflow_d = 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
        idx_d    = (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
        if (out_last) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      if (push_ok && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (pop && !push_ok) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge sclr) begin
    if (!sclr) begin
      ce_pipe_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      ce_pipe_q   <= ce_pipe_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  // Sample storage; contents are masked by out_valid so no reset is needed.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule
